// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between instruction fetch (F)
// and the load/store unit (L). One transaction in flight, L has priority
// over F, with a streak limit so F is not starved, plus a watchdog abort.
module mem_port_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_f_req,
  input  logic [31:0] i_f_addr,
  output logic        o_f_gnt,
  output logic        o_f_rvalid,
  output logic [31:0] o_f_rdata,
  input  logic        i_l_req,
  input  logic [31:0] i_l_addr,
  input  logic        i_l_wren,
  input  logic [31:0] i_l_wdata,
  input  logic [3:0]  i_l_bmask,
  output logic        o_l_gnt,
  output logic        o_l_rvalid,
  output logic [31:0] o_l_rdata,
  output logic        o_err,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wren,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_L = 2'd2
  } state_t;

  localparam logic [3:0]  STREAK_MAX = 4'(MAX_BURST);
  // Watchdog counts completed BUSY cycles; abort fires in the TIMEOUT-th one.
  localparam logic [15:0] WD_LAST    = 16'(TIMEOUT - 1);
  localparam bit          WD_EN      = (TIMEOUT != 0);

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [15:0] wd_q, wd_d;
  logic [31:0] addr_q, addr_d;
  logic        wren_q, wren_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  bmask_q, bmask_d;
  logic        f_rvalid_q, f_rvalid_d;
  logic        l_rvalid_q, l_rvalid_d;
  logic        err_q, err_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic [31:0] l_rdata_q, l_rdata_d;

  logic f_gnt;
  logic l_gnt;
  logic busy;
  logic timeout;

  assign busy    = (state_q != IDLE);
  // Ack has priority over a coincident watchdog expiry.
  assign timeout = WD_EN && busy && !i_mem_ack && (wd_q == WD_LAST);

  // Grant in IDLE only: L wins a tie unless its streak has hit the limit.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (state_q == IDLE && !i_reset) begin
      if (i_f_req && (!i_l_req || streak_q == STREAK_MAX)) begin
        f_gnt = 1'b1;
      end else if (i_l_req) begin
        l_gnt = 1'b1;
      end
    end
  end

  // Next-state, command capture, watchdog and response generation.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    wd_d       = wd_q;
    addr_d     = addr_q;
    wren_d     = wren_q;
    wdata_d    = wdata_q;
    bmask_d    = bmask_q;
    f_rvalid_d = 1'b0;
    l_rvalid_d = 1'b0;
    err_d      = 1'b0;
    f_rdata_d  = f_rdata_q;
    l_rdata_d  = l_rdata_q;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (f_gnt) begin
          state_d  = BUSY_F;
          streak_d = '0;
          addr_d   = i_f_addr;
          wren_d   = 1'b0;
          wdata_d  = '0;
          bmask_d  = '0;
        end else if (l_gnt) begin
          state_d = BUSY_L;
          if (!i_f_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
          end
          addr_d  = i_l_addr;
          wren_d  = i_l_wren;
          wdata_d = i_l_wdata;
          bmask_d = i_l_bmask;
        end
      end
      BUSY_F, BUSY_L: begin
        wd_d = wd_q + 16'd1;
        if (i_mem_ack || timeout) begin
          state_d = IDLE;
          err_d   = !i_mem_ack;
          if (state_q == BUSY_F) begin
            f_rvalid_d = 1'b1;
            f_rdata_d  = i_mem_ack ? i_mem_rdata : 32'd0;
          end else begin
            l_rvalid_d = 1'b1;
            l_rdata_d  = (i_mem_ack && !wren_q) ? i_mem_rdata : 32'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      wd_q       <= '0;
      addr_q     <= '0;
      wren_q     <= 1'b0;
      wdata_q    <= '0;
      bmask_q    <= '0;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      err_q      <= 1'b0;
      f_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      wd_q       <= wd_d;
      addr_q     <= addr_d;
      wren_q     <= wren_d;
      wdata_q    <= wdata_d;
      bmask_q    <= bmask_d;
      f_rvalid_q <= f_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
      err_q      <= err_d;
      f_rdata_q  <= f_rdata_d;
      l_rdata_q  <= l_rdata_d;
    end
  end

  assign o_f_gnt     = f_gnt;
  assign o_l_gnt     = l_gnt;
  assign o_f_rvalid  = f_rvalid_q;
  assign o_l_rvalid  = l_rvalid_q;
  assign o_f_rdata   = f_rdata_q;
  assign o_l_rdata   = l_rdata_q;
  assign o_err       = err_q;
  assign o_mem_req   = busy;
  assign o_mem_addr  = addr_q;
  assign o_mem_wren  = wren_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_bmask = bmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int MAXB = 4;
  localparam int TO   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, l_req, l_wren, mem_ack;
  logic [31:0] f_addr, l_addr, l_wdata, mem_rdata;
  logic [3:0]  l_bmask;
  logic        o_f_gnt, o_f_rvalid, o_l_gnt, o_l_rvalid, o_err;
  logic        o_mem_req, o_mem_wren;
  logic [31:0] o_f_rdata, o_l_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_bmask;

  mem_port_arbiter #(.MAX_BURST(MAXB), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(o_f_gnt),
    .o_f_rvalid(o_f_rvalid), .o_f_rdata(o_f_rdata),
    .i_l_req(l_req), .i_l_addr(l_addr), .i_l_wren(l_wren),
    .i_l_wdata(l_wdata), .i_l_bmask(l_bmask), .o_l_gnt(o_l_gnt),
    .o_l_rvalid(o_l_rvalid), .o_l_rdata(o_l_rdata), .o_err(o_err),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wren(o_mem_wren),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the port, how long it has waited, the
  // current L streak, the pending response and the last delivered data.
  int          m_owner;   // 0 none, 1 fetch, 2 lsu
  int          m_wait;
  int          m_streak;
  bit          m_rsp;
  int          m_rsp_who;
  logic [31:0] m_rsp_data;
  bit          m_rsp_err;
  logic [31:0] m_f_rdata, m_l_rdata;
  logic [31:0] m_addr, m_wdata;
  logic        m_wren;
  logic [3:0]  m_bmask;
  bit          g_f, g_l;
  int          gnt_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_wait = 0; m_streak = 0; m_rsp = 0; m_rsp_who = 0;
    m_rsp_data = '0; m_rsp_err = 0; m_f_rdata = '0; m_l_rdata = '0;
    m_addr = '0; m_wdata = '0; m_wren = 0; m_bmask = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {26'd0, o_f_gnt, o_l_gnt, o_mem_req, o_f_rvalid, o_l_rvalid, o_err}, 32'd0);
    chk({tag, "_rdata"}, o_f_rdata | o_l_rdata, 32'd0);
    chk({tag, "_mem"}, o_mem_addr | o_mem_wdata | {27'd0, o_mem_wren, o_mem_bmask}, 32'd0);
  endtask

  // One clock cycle: check outputs against the model, clock, advance model.
  task automatic cycle();
    bit ef, el;
    #2;
    ef = (m_owner == 0) && f_req && (!l_req || m_streak == MAXB);
    el = (m_owner == 0) && l_req && !ef;
    chk("ctrl", {26'd0, o_f_gnt, o_l_gnt, o_mem_req, o_f_rvalid, o_l_rvalid, o_err},
        {26'd0, ef, el, m_owner != 0, m_rsp && m_rsp_who == 1, m_rsp && m_rsp_who == 2, m_rsp && m_rsp_err});
    chk("f_rdata", o_f_rdata, m_f_rdata);
    chk("l_rdata", o_l_rdata, m_l_rdata);
    if (m_owner != 0) begin
      chk("mem_addr", o_mem_addr, m_addr);
      chk("mem_wdata", o_mem_wdata, m_wdata);
      chk("mem_ctl", {27'd0, o_mem_wren, o_mem_bmask}, {27'd0, m_wren, m_bmask});
    end
    @(posedge clk);
    g_f = ef;
    g_l = el;
    if (rst) begin
      model_reset();
    end else begin
      m_rsp = 0;
      if (m_owner != 0) begin
        m_wait++;
        if (mem_ack) begin
          m_rsp = 1; m_rsp_who = m_owner; m_rsp_err = 0;
          m_rsp_data = (m_owner == 2 && m_wren) ? 32'd0 : mem_rdata;
          m_owner = 0;
        end else if (TO != 0 && m_wait == TO) begin
          m_rsp = 1; m_rsp_who = m_owner; m_rsp_err = 1; m_rsp_data = 32'd0;
          m_owner = 0;
        end
      end else if (ef) begin
        m_owner = 1; m_wait = 0; m_streak = 0;
        m_addr = f_addr; m_wren = 0; m_wdata = '0; m_bmask = '0;
        gnt_log.push_back(1);
      end else if (el) begin
        m_owner = 2; m_wait = 0;
        m_streak = f_req ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 0;
        m_addr = l_addr; m_wren = l_wren; m_wdata = l_wdata; m_bmask = l_bmask;
        gnt_log.push_back(2);
      end
      if (m_rsp) begin
        if (m_rsp_who == 1) m_f_rdata = m_rsp_data;
        else m_l_rdata = m_rsp_data;
      end
    end
    #1;
    if (ef) f_req = 0;
    if (el) l_req = 0;
  endtask

  initial begin
    int k;
    rst = 1; f_req = 0; l_req = 0; l_wren = 0; mem_ack = 0;
    f_addr = '0; l_addr = '0; l_wdata = '0; l_bmask = '0; mem_rdata = '0;
    model_reset();

    // Reset state
    @(posedge clk); #1;
    chk_all_zero("reset");
    cycle();
    rst = 0;
    cycle();
    $display("TXN reset done");

    // Single fetch, zero-wait memory
    f_req = 1; f_addr = 32'h10;
    cycle();
    chk("fetch_gnt", 32'(g_f), 32'd1);
    chk("fetch_t1", {o_mem_req, o_mem_addr[30:0]}, {1'b1, 31'h10});
    mem_ack = 1; mem_rdata = 32'h13;
    cycle();
    mem_ack = 0;
    chk("fetch_rsp", {30'd0, o_f_rvalid, o_err}, 32'd2);
    chk("fetch_rdata", o_f_rdata, 32'h13);
    cycle();
    $display("TXN fetch addr=00000010 rdata=%h", o_f_rdata);

    // Store with three memory wait cycles
    l_req = 1; l_addr = 32'h100; l_wren = 1; l_wdata = 32'hDEADBEEF; l_bmask = 4'hF;
    cycle();
    chk("store_gnt", 32'(g_l), 32'd1);
    repeat (3) cycle();
    mem_ack = 1; mem_rdata = 32'h5555AAAA;
    cycle();
    mem_ack = 0;
    chk("store_rsp", {30'd0, o_l_rvalid, o_err}, 32'd2);
    chk("store_rdata", o_l_rdata, 32'd0);
    cycle();
    $display("TXN store addr=00000100 wdata=deadbeef");

    // Starvation protection: both request continuously
    gnt_log.delete();
    for (int c = 0; c < 20; c++) begin
      f_req = 1; l_req = 1; l_wren = 0; f_addr = $urandom; l_addr = $urandom;
      mem_ack = 1; mem_rdata = $urandom;
      cycle();
    end
    f_req = 0; l_req = 0;
    cycle();
    cycle();
    mem_ack = 0;
    chk("starve_count", 32'(gnt_log.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      k = (i % 5 == 4) ? 1 : 2;
      chk($sformatf("starve_%0d", i), 32'(gnt_log[i]), 32'(k));
    end
    $display("TXN starvation grants=%0d", gnt_log.size());

    // Simultaneous first requests: L first, F right after L completes
    f_req = 1; l_req = 1; f_addr = 32'h200; l_addr = 32'h300;
    cycle();
    chk("sim_only_l", {30'd0, g_f, g_l}, 32'd1);
    mem_ack = 1; mem_rdata = 32'hCAFE0001;
    cycle();
    mem_ack = 0;
    chk("sim_l_rsp", 32'(o_l_rvalid), 32'd1);
    cycle();
    chk("sim_f_gnt", 32'(g_f), 32'd1);
    mem_ack = 1; mem_rdata = 32'hCAFE0002;
    cycle();
    mem_ack = 0;
    cycle();
    $display("TXN simultaneous l_rdata=%h f_rdata=%h", o_l_rdata, o_f_rdata);

    // Watchdog abort of an unacknowledged fetch
    f_req = 1; f_addr = 32'h400;
    cycle();
    k = 1;
    while (k < 20 && o_f_rvalid !== 1'b1) begin
      cycle();
      k++;
    end
    chk("to_latency", 32'(k), 32'(TO + 1));
    chk("to_rsp", {30'd0, o_f_rvalid, o_err}, 32'd3);
    chk("to_rdata", o_f_rdata, 32'd0);
    cycle();
    f_req = 1; f_addr = 32'h404;
    cycle();
    mem_ack = 1; mem_rdata = 32'h77;
    cycle();
    mem_ack = 0;
    chk("to_after", {30'd0, o_f_rvalid, o_err}, 32'd2);
    cycle();
    $display("TXN timeout latency=%0d", k);

    // Reset in the middle of a load
    l_req = 1; l_wren = 0; l_addr = 32'h500;
    cycle();
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    chk_all_zero("midrst");
    mem_ack = 1; mem_rdata = 32'h99;
    cycle();
    mem_ack = 0;
    f_req = 1; f_addr = 32'h600;
    cycle();
    chk("midrst_fgnt", 32'(g_f), 32'd1);
    mem_ack = 1; mem_rdata = 32'h66;
    cycle();
    mem_ack = 0;
    cycle();
    $display("TXN reset-mid-load recovered f_rdata=%h", o_f_rdata);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1; f_req = 0; l_req = 0;
      end else begin
        rst = 0;
        if (!f_req && $urandom_range(0, 2) == 0) begin
          f_req = 1; f_addr = $urandom;
        end
        if (!l_req && $urandom_range(0, 2) == 0) begin
          l_req = 1; l_addr = $urandom; l_wren = 1'($urandom_range(0, 1));
          l_wdata = $urandom; l_bmask = 4'($urandom_range(0, 15));
        end
      end
      mem_ack = ($urandom_range(0, 9) < 3);
      mem_rdata = $urandom;
      cycle();
    end
    rst = 0;
    $display("TXN random traffic grants=%0d", gnt_log.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
